// File: rtl/aes_decipher_pkg.sv
// Shared AES constants, types and GF(2^8) helpers for the iterative inverse cipher.
package aes_pkg;

    localparam int unsigned NR    = 10;
    localparam int unsigned BLK_W = 128;

    typedef logic [BLK_W-1:0] aes_block_t;
    typedef logic [31:0]      aes_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } dec_state_t;

    // Element 0 sits in the most significant byte of each packed table.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Byte b = row + 4*col; row r rotates right by r columns.
    function automatic aes_block_t inv_shift_rows(input aes_block_t s);
        aes_block_t o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_word_t inv_mix_column(input aes_word_t w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
                gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
                gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
                gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
    endfunction

endpackage

// File: rtl/aes_decipher_if.sv
// Request/response bundle between the AES top and the inverse cipher core.
interface aes_decipher_if;
    import aes_pkg::*;

    logic       en;
    logic       decipher_new_en;
    aes_block_t cipher_text_in;
    aes_block_t round_key_10;
    aes_block_t plain_text_out;
    logic       decipher_ready;

    modport master (
        output en, decipher_new_en, cipher_text_in, round_key_10,
        input  plain_text_out, decipher_ready
    );

    modport slave (
        input  en, decipher_new_en, cipher_text_in, round_key_10,
        output plain_text_out, decipher_ready
    );
endinterface

// File: rtl/aes_decipher_inv_round.sv
// Combinational AES inverse round; the last round skips InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_block_t i_state,
    input  aes_block_t i_key,
    input  logic       i_last,
    output aes_block_t o_state
);

    aes_block_t w_isr;
    aes_block_t w_isb;
    aes_block_t w_ark;

    always_comb begin
        w_isb   = '0;
        w_isr   = inv_shift_rows(i_state);
        for (int unsigned i = 0; i < 16; i++) begin
            w_isb[127-8*i -: 8] = INV_SBOX[w_isr[127-8*i -: 8]];
        end
        w_ark   = w_isb ^ i_key;
        o_state = w_ark;
        if (!i_last) begin
            for (int unsigned c = 0; c < 4; c++) begin
                o_state[127-32*c -: 32] = inv_mix_column(w_ark[127-32*c -: 32]);
            end
        end
    end

endmodule

// File: rtl/aes_decipher.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys rolled back on the fly.
module aes_decipher
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    aes_decipher_if.slave bus
);

    dec_state_t r_fsm, w_fsm_nxt;
    logic [3:0] r_rnd, w_rnd_nxt;
    aes_block_t r_blk, w_blk_nxt;
    aes_block_t r_key, w_key_nxt;
    aes_block_t r_pt,  w_pt_nxt;
    logic       r_ready, w_ready_nxt;

    aes_word_t  w_p0, w_p1, w_p2, w_p3;
    aes_block_t w_key_prev;
    aes_block_t w_round_out;

    // Undo one key-expansion step: K(r+1) -> K(r), using RCON[r+1].
    always_comb begin
        w_p3       = r_key[31:0]   ^ r_key[63:32];
        w_p2       = r_key[63:32]  ^ r_key[95:64];
        w_p1       = r_key[95:64]  ^ r_key[127:96];
        w_p0       = r_key[127:96] ^ sub_word({w_p3[23:0], w_p3[31:24]})
                   ^ {RCON[r_rnd + 4'd1], 24'h0};
        w_key_prev = {w_p0, w_p1, w_p2, w_p3};
    end

    aes_inv_round u_inv_round (
        .i_state (r_blk),
        .i_key   (w_key_prev),
        .i_last  (r_rnd == 4'd0),
        .o_state (w_round_out)
    );

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_rnd_nxt   = r_rnd;
        w_blk_nxt   = r_blk;
        w_key_nxt   = r_key;
        w_pt_nxt    = r_pt;
        w_ready_nxt = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (bus.decipher_new_en) begin
                    w_blk_nxt = bus.cipher_text_in ^ bus.round_key_10;
                    w_key_nxt = bus.round_key_10;
                    w_rnd_nxt = 4'(NR - 1);
                    w_fsm_nxt = ROUND;
                end
            end
            ROUND: begin
                w_blk_nxt = w_round_out;
                w_key_nxt = w_key_prev;
                if (r_rnd == 4'd0) w_fsm_nxt = DONE;
                else               w_rnd_nxt = r_rnd - 4'd1;
            end
            DONE: begin
                w_pt_nxt    = r_blk;
                w_ready_nxt = 1'b1;
                w_fsm_nxt   = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // en gates every register, so a ready pulse stretches while en is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm   <= IDLE;
            r_rnd   <= '0;
            r_blk   <= '0;
            r_key   <= '0;
            r_pt    <= '0;
            r_ready <= 1'b0;
        end else if (bus.en) begin
            r_fsm   <= w_fsm_nxt;
            r_rnd   <= w_rnd_nxt;
            r_blk   <= w_blk_nxt;
            r_key   <= w_key_nxt;
            r_pt    <= w_pt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign bus.plain_text_out = r_pt;
    assign bus.decipher_ready = r_ready;

endmodule

// File: tb/tb_aes_decipher.sv
// Bench for aes_decipher: FIPS-197 vectors, control corner cases and random loopback via a forward-cipher model.
module tb_aes_decipher;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] m_sbox [256];

    aes_decipher_if u_if ();

    aes_decipher u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from the multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic void m_encrypt(input logic [127:0] key, input logic [127:0] pt,
                                      output logic [127:0] ct, output logic [127:0] rk10);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]], m_sbox[tmp[31:24]]}
                    ^ {rc, 24'h0};
                rc  = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = m_sbox[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = m_mul(a0,8'h02) ^ m_mul(a1,8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ m_mul(a1,8'h02) ^ m_mul(a2,8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ m_mul(a2,8'h02) ^ m_mul(a3,8'h03);
                    s[4*c+3] = m_mul(a0,8'h03) ^ a1 ^ a2 ^ m_mul(a3,8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        rk10 = {w[40], w[41], w[42], w[43]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] ct, input logic [127:0] key);
        u_if.cipher_text_in  = ct;
        u_if.round_key_10    = key;
        u_if.decipher_new_en = 1'b1;
        tick();
        u_if.decipher_new_en = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int cyc);
        int k;
        k   = 0;
        cyc = -1;
        while (cyc < 0 && k < budget) begin
            k++;
            tick();
            if (u_if.decipher_ready) cyc = k;
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] exp, input bit full);
        int cyc;
        accept(ct, key);
        wait_ready(20, cyc);
        if (full) check_eq({tag, " latency"}, 128'(cyc), 128'd11);
        check_eq(tag, u_if.plain_text_out, exp);
        if (full) begin
            tick();
            check_eq({tag, " single pulse"}, 128'(u_if.decipher_ready), 128'd0);
        end
    endtask

    initial begin
        int first, second, pulses;
        logic [127:0] cap_a, cap_b, key, pt, ct, rk;

        build_sbox();
        reset_n              = 1'b0;
        u_if.en              = 1'b1;
        u_if.decipher_new_en = 1'b0;
        u_if.cipher_text_in  = '0;
        u_if.round_key_10    = '0;
        tick(); tick();
        check_eq("reset pt", u_if.plain_text_out, '0);
        check_eq("reset ready", 128'(u_if.decipher_ready), 128'd0);
        reset_n = 1'b1;
        tick();

        run_block("fips C.1", C1_CT, C1_K, C1_PT, 1'b1);
        run_block("fips B", B_CT, B_K, B_PT, 1'b1);

        // Busy: C.1 request at E3 ignored, en low over E6..E10.
        accept(B_CT, B_K);
        first = -1; pulses = 0; cap_a = '0;
        for (int k = 1; k <= 30; k++) begin
            u_if.en = !(k >= 6 && k <= 10);
            if (k == 3) begin
                u_if.cipher_text_in  = C1_CT;
                u_if.round_key_10    = C1_K;
                u_if.decipher_new_en = 1'b1;
            end else begin
                u_if.decipher_new_en = 1'b0;
            end
            tick();
            if (u_if.decipher_ready) begin
                pulses++;
                if (first < 0) begin first = k; cap_a = u_if.plain_text_out; end
            end
        end
        u_if.en = 1'b1;
        check_eq("busy latency", 128'(first), 128'd16);
        check_eq("busy pulse count", 128'(pulses), 128'd1);
        check_eq("busy result", cap_a, B_PT);

        // Ready stretches while en is low after the pulse.
        accept(C1_CT, C1_K);
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            u_if.en = !(k == 12 || k == 13);
            tick();
            if (u_if.decipher_ready) pulses++;
        end
        u_if.en = 1'b1;
        check_eq("stretch cycles", 128'(pulses), 128'd3);
        check_eq("stretch result", u_if.plain_text_out, C1_PT);

        // Reset mid-block.
        accept(B_CT, B_K);
        for (int k = 1; k <= 4; k++) tick();
        reset_n = 1'b0;
        #1;
        check_eq("midreset pt", u_if.plain_text_out, '0);
        check_eq("midreset ready", 128'(u_if.decipher_ready), 128'd0);
        tick(); tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (u_if.decipher_ready) pulses++;
        end
        check_eq("aborted pulses", 128'(pulses), 128'd0);
        check_eq("aborted pt", u_if.plain_text_out, '0);
        run_block("after reset C.1", C1_CT, C1_K, C1_PT, 1'b1);

        // Back-to-back: second request at E12.
        accept(B_CT, B_K);
        first = -1; second = -1; cap_a = '0; cap_b = '0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 12) begin
                u_if.cipher_text_in  = C1_CT;
                u_if.round_key_10    = C1_K;
                u_if.decipher_new_en = 1'b1;
            end else begin
                u_if.decipher_new_en = 1'b0;
            end
            tick();
            if (k == 22) check_eq("b2b hold", u_if.plain_text_out, B_PT);
            if (u_if.decipher_ready) begin
                if (first < 0) begin first = k; cap_a = u_if.plain_text_out; end
                else if (second < 0) begin second = k; cap_b = u_if.plain_text_out; end
            end
        end
        check_eq("b2b first pulse", 128'(first), 128'd11);
        check_eq("b2b second pulse", 128'(second), 128'd23);
        check_eq("b2b first pt", cap_a, B_PT);
        check_eq("b2b second pt", cap_b, C1_PT);

        for (int i = 0; i < 1000; i++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            m_encrypt(key, pt, ct, rk);
            run_block("random loopback", ct, rk, pt, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_decipher.md
Name: aes_decipher

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 InvCipher); one round per clock.
- Receiver-side counterpart of the cipher datapath.
- Takes a ciphertext block and the final round key (round_key_10), regenerates round keys backwards on the fly, and returns the plaintext with a ready pulse.
- Sits beside the cipher core under the same AES top and shares its enable.

Parameters:
- NR, 10, number of AES rounds (AES-128 only; fixed).
- BLK_W, 128, block and key width in bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  global core enable; 0 freezes all state.
- decipher_new_en  input  1  start request; sampled only in IDLE with en=1.
- cipher_text_in  input  128  ciphertext block; byte 0 is in [127:120].
- round_key_10  input  128  last round key of the AES-128 key schedule.
- plain_text_out  output  128  recovered plaintext; held until the next acceptance.
- decipher_ready  output  1  one-cycle pulse when plain_text_out becomes valid.

Behaviour:
- Reset is asynchronous, active-low, on one clock. While reset_n=0:
  - FSM=IDLE, round counter=0, state and key registers=0.
  - plain_text_out=0, decipher_ready=0.
- Reset mid-operation aborts the block. No ready pulse is issued for it.
- FSM states: IDLE, ROUND, DONE.
- IDLE: on en=1 and decipher_new_en=1 (acceptance edge E0):
  - state <= cipher_text_in ^ round_key_10.
  - key <= round_key_10.
  - rnd <= 9.
  - Go to ROUND.
- ROUND (en=1), each edge, with r=rnd:
  - Inverse key step from K(r+1)=(w0,w1,w2,w3) to K(r)=(p0,p1,p2,p3):
    - p3=w3^w2, p2=w2^w1, p1=w1^w0.
    - p0 = w0 ^ SubWord(RotWord(p3)) ^ {RCON[r+1],24'h0}.
    - RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - If r>=1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ K(r)).
  - If r==0: state <= InvSubBytes(InvShiftRows(state)) ^ K(0). Go to DONE.
  - Otherwise rnd <= rnd-1.
- DONE: one cycle.
  - plain_text_out <= state; decipher_ready <= 1 for exactly one cycle.
  - Return to IDLE.
- Latency:
  - Plaintext is computed by edge E10.
  - plain_text_out and decipher_ready are registered at E11, so visible in the cycle after E11.
  - Back-to-back requests: the next acceptance is possible at E12. Throughput is one block per 12 cycles.
- en=0: every register holds, including decipher_ready (a pulse stretches while en=0). Processing resumes where it left off.
- decipher_new_en while in ROUND or DONE: ignored, not queued.
- Inputs are sampled only at E0. Later changes to cipher_text_in or round_key_10 do not affect the block in flight.
- GF(2^8) arithmetic: xtime uses polynomial 0x11b. InvMixColumns coefficients are 0e,0b,0d,09.

Decomposition:
- Package aes_pkg:
  - SBOX[256] and INV_SBOX[256] constant byte arrays.
  - RCON[1..10].
  - Typedefs aes_block_t (logic [127:0]) and aes_word_t (logic [31:0]).
  - Functions xtime, gmul, inv_shift_rows, inv_mix_column (one word).
- Sub-module aes_inv_round: combinational inverse round.
  - Inputs: state, round key, last_round flag. Output: next state.
  - Instantiated once; the key step and FSM stay in aes_decipher.

Test Plan:
- FIPS-197 App. C.1:
  - Stimulus: cipher_text_in=69c4e0d86a7b0430d8cdb78070b4c55a, round_key_10=13111d7fe3944a17f307a78b4d2b30c5.
  - Response: plain_text_out=00112233445566778899aabbccddeeff; decipher_ready single pulse 11 cycles after the acceptance cycle.
- FIPS-197 App. B:
  - Stimulus: cipher_text_in=3925841d02dc09fbdc118597196a0b32, round_key_10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Response: plain_text_out=3243f6a8885a308d313198a2e0370734.
- Busy and enable control:
  - Stimulus: run the App. B request. Re-assert decipher_new_en with C.1 data at E3. Hold en=0 for 5 cycles at E6.
  - Response: single ready pulse 16 cycles after E0 with the App. B result; the C.1 request is ignored.
- Reset mid-operation:
  - Stimulus: pull reset_n low at E5, release, then issue a C.1 request.
  - Response: outputs are 0 with no pulse during the aborted block; the C.1 result is correct afterwards.
- Back-to-back:
  - Stimulus: App. B request, then C.1 request at the first IDLE cycle (E12).
  - Response: two pulses 12 cycles apart with the correct plaintexts. plain_text_out holds the App. B value until the C.1 pulse.
- Random loopback:
  - Stimulus: 1000 random key/plaintext pairs encrypted by the reference cipher model.
  - Response: plain_text_out matches the original plaintext for every pair.
